// File: rtl/hash_job_ctrl.sv
// hash_job_ctrl: job sequencer for one heavy_hash + comparator mining lane.
// Loads the 256-bit target into the comparator FIFO (LSW first), starts the
// comparator, issues nonces, counts retired hashes, captures the golden nonce,
// drains the lane through the stop/ack handshake and reports status.
// Optional: HASH_JOB_STOP_WDOG_EN enables a STOP_TO-cycle stop-drain watchdog.
module hash_job_ctrl #(
  parameter int unsigned NONCE_W = 64,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STOP_TO = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [255:0]       job_target,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [CNT_W-1:0]   job_nonce_count,
  input  logic               abort,
  output logic [31:0]        target_data,
  output logic               target_we,
  input  logic               target_full,
  output logic               cmp_start,
  output logic               cmp_stop,
  input  logic               cmp_stop_ack,
  input  logic               core_all_empty,
  input  logic               cmp_result,
  input  logic               hash_retire,
  output logic [NONCE_W-1:0] nonce_data,
  output logic               nonce_valid,
  input  logic               nonce_ready,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               aborted,
  output logic               timeout,
  output logic [NONCE_W-1:0] golden_nonce
);

  localparam int unsigned WD_W = $clog2(STOP_TO + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TGT,
    START,
    RUN,
    STOP_WAIT,
    REPORT
  } state_t;

  state_t             state, state_nx;
  logic [255:0]       tgt_q;
  logic [NONCE_W-1:0] start_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   retired;
  logic [2:0]         wcnt;
  logic               drain_ok;
  logic               drain_q;
  logic [WD_W-1:0]    wdog;
  logic               wdog_exp;
  logic               set_found;
  logic               set_abort;

  assign job_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == REPORT);
  assign cmp_stop    = (state == STOP_WAIT);
  assign target_data = (state == LOAD_TGT) ? tgt_q[{wcnt, 5'd0} +: 32] : '0;
  assign target_we   = (state == LOAD_TGT) && !target_full && !abort;
  assign cmp_start   = (state == START) && !abort && cmp_stop_ack;
  assign nonce_valid = (state == RUN) && (issued < count_q);
  assign nonce_data  = start_q + NONCE_W'(issued);
  assign drain_ok    = cmp_stop_ack && core_all_empty;

`ifdef HASH_JOB_STOP_WDOG_EN
  assign wdog_exp = (wdog == WD_W'(STOP_TO - 1));
`else
  assign wdog_exp = 1'b0;
`endif

  // Next-state and exit-cause decode; hit outranks abort outranks completion.
  always_comb begin
    state_nx  = state;
    set_found = 1'b0;
    set_abort = 1'b0;
    case (state)
      IDLE: begin
        if (job_valid) state_nx = (job_nonce_count == '0) ? REPORT : LOAD_TGT;
      end
      LOAD_TGT: begin
        if (abort) begin
          set_abort = 1'b1;
          state_nx  = STOP_WAIT;
        end else if (target_we && (wcnt == 3'd7)) begin
          state_nx = START;
        end
      end
      START: begin
        if (abort) begin
          set_abort = 1'b1;
          state_nx  = STOP_WAIT;
        end else if (cmp_stop_ack) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cmp_result) begin
          set_found = 1'b1;
          state_nx  = STOP_WAIT;
        end else if (abort) begin
          set_abort = 1'b1;
          state_nx  = STOP_WAIT;
        end else if (retired == count_q) begin
          state_nx = STOP_WAIT;
        end
      end
      STOP_WAIT: begin
        if ((drain_ok && drain_q) || wdog_exp) state_nx = REPORT;
      end
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, job latches, counters and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tgt_q        <= '0;
      start_q      <= '0;
      count_q      <= '0;
      issued       <= '0;
      retired      <= '0;
      wcnt         <= '0;
      drain_q      <= 1'b0;
      wdog         <= '0;
      found        <= 1'b0;
      aborted      <= 1'b0;
      timeout      <= 1'b0;
      golden_nonce <= '0;
    end else begin
      state   <= state_nx;
      drain_q <= (state == STOP_WAIT) && drain_ok;
      wdog    <= (state == STOP_WAIT) ? wdog + 1'b1 : '0;
      if (state == IDLE && job_valid) begin
        tgt_q        <= job_target;
        start_q      <= job_nonce_start;
        count_q      <= job_nonce_count;
        issued       <= '0;
        retired      <= '0;
        wcnt         <= '0;
        found        <= 1'b0;
        aborted      <= 1'b0;
        timeout      <= 1'b0;
        golden_nonce <= '0;
      end
      if (target_we) wcnt <= wcnt + 1'b1;
      if (nonce_valid && nonce_ready) issued <= issued + 1'b1;
      if (state == RUN && hash_retire && (retired < count_q)) retired <= retired + 1'b1;
      // Golden nonce uses the registered retire count, so a retire in the
      // same cycle as the first hit is not included.
      if (set_found) begin
        found        <= 1'b1;
        golden_nonce <= start_q + NONCE_W'(retired);
      end
      if (set_abort) aborted <= 1'b1;
      if (state == STOP_WAIT && wdog_exp && !(drain_ok && drain_q)) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hash_job_ctrl.sv
// Scoreboard bench for hash_job_ctrl: expected target words, nonces and
// job status are queued at submission and popped by a monitor at negedge.
module tb_hash_job_ctrl;

  logic         clk;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_target;
  logic [63:0]  job_nonce_start;
  logic [31:0]  job_nonce_count;
  logic         abort;
  logic [31:0]  target_data;
  logic         target_we;
  logic         target_full;
  logic         cmp_start;
  logic         cmp_stop;
  logic         cmp_stop_ack;
  logic         core_all_empty;
  logic         cmp_result;
  logic         hash_retire;
  logic [63:0]  nonce_data;
  logic         nonce_valid;
  logic         nonce_ready;
  logic         busy;
  logic         done;
  logic         found;
  logic         aborted;
  logic         timeout;
  logic [63:0]  golden_nonce;

  hash_job_ctrl #(.NONCE_W(64), .CNT_W(32), .STOP_TO(16)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_target(job_target), .job_nonce_start(job_nonce_start),
    .job_nonce_count(job_nonce_count), .abort(abort),
    .target_data(target_data), .target_we(target_we), .target_full(target_full),
    .cmp_start(cmp_start), .cmp_stop(cmp_stop), .cmp_stop_ack(cmp_stop_ack),
    .core_all_empty(core_all_empty), .cmp_result(cmp_result),
    .hash_retire(hash_retire), .nonce_data(nonce_data), .nonce_valid(nonce_valid),
    .nonce_ready(nonce_ready), .busy(busy), .done(done), .found(found),
    .aborted(aborted), .timeout(timeout), .golden_nonce(golden_nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        found;
    logic        aborted;
    logic        timeout;
    logic [63:0] golden;
    int          starts;
    int          stop_len;
  } status_t;

  logic [31:0] tgt_q[$];
  logic [63:0] nonce_q[$];
  status_t     stat_q[$];

  int checks = 0;
  int passes = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  function automatic void fail_now(string name);
    checks++;
    $display("FAIL %s: got event with nothing expected, required none", name);
  endfunction

  // Lane environment configuration (written by the main sequence while idle).
  int hit_after   = -1;  // raise cmp_result once this many retires happened
  int ready_mode  = 0;   // 0 always ready, 1 toggle, 2 ready until ready_limit issued
  int ready_limit = 0;
  int ack_mode    = 0;   // 0 ack high, 1 glitchy ack during stop, 2 ack stuck low in stop

  int   rdone, pend, iss, stop_idx;
  logic hs_s, rt_s;

  // Core/comparator model: retires issued nonces one per cycle, raises hits.
  initial begin
    hash_retire = 1'b0; cmp_result = 1'b0; nonce_ready = 1'b0;
    cmp_stop_ack = 1'b1; core_all_empty = 1'b1;
    rdone = 0; pend = 0; iss = 0; stop_idx = 0;
    forever begin
      @(negedge clk);
      hs_s = nonce_valid && nonce_ready;
      rt_s = hash_retire;
      @(posedge clk); #1;
      if (busy !== 1'b1) begin
        rdone = 0; pend = 0; iss = 0; hash_retire = 1'b0; cmp_result = 1'b0;
      end else begin
        if (hs_s) begin pend++; iss++; end
        if (rt_s) begin pend--; rdone++; end
        if (hit_after >= 0 && rdone >= hit_after) begin
          cmp_result = 1'b1; hash_retire = 1'b0;
        end else begin
          hash_retire = (pend > 0);
        end
      end
      case (ready_mode)
        1:       nonce_ready = ~nonce_ready;
        2:       nonce_ready = (iss < ready_limit);
        default: nonce_ready = 1'b1;
      endcase
      if (cmp_stop === 1'b1) begin
        case (ack_mode)
          1:       cmp_stop_ack = (stop_idx == 3) || (stop_idx >= 5);
          2:       cmp_stop_ack = 1'b0;
          default: cmp_stop_ack = 1'b1;
        endcase
        stop_idx++;
      end else begin
        stop_idx = 0;
        cmp_stop_ack = 1'b1;
      end
      core_all_empty = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  logic [63:0] prev_nd;
  logic        prev_stall = 1'b0;
  int          starts_m = 0;
  int          stop_m = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_stall = 1'b0; starts_m = 0; stop_m = 0;
      end else begin
        if (target_we) begin
          check("we_while_full", {63'd0, target_full}, 64'd0);
          if (tgt_q.size() == 0) fail_now("unexpected_target_we");
          else check("target_word", {32'd0, target_data}, {32'd0, tgt_q.pop_front()});
        end
        if (prev_stall && nonce_valid) check("nonce_hold", nonce_data, prev_nd);
        if (nonce_valid && nonce_ready) begin
          if (nonce_q.size() == 0) fail_now("unexpected_nonce");
          else check("nonce", nonce_data, nonce_q.pop_front());
        end
        if (nonce_valid && cmp_stop) fail_now("nonce_valid_in_stop");
        prev_stall = nonce_valid && !nonce_ready;
        prev_nd    = nonce_data;
        if (cmp_start) starts_m++;
        if (cmp_stop) stop_m++;
        if (done) begin
          if (stat_q.size() == 0) fail_now("unexpected_done");
          else begin
            status_t e;
            e = stat_q.pop_front();
            check("found", {63'd0, found}, {63'd0, e.found});
            check("aborted", {63'd0, aborted}, {63'd0, e.aborted});
            check("timeout", {63'd0, timeout}, {63'd0, e.timeout});
            check("golden_nonce", golden_nonce, e.golden);
            check("cmp_start_count", 64'(starts_m), 64'(e.starts));
            check("stop_cycles", 64'(stop_m), 64'(e.stop_len));
          end
          starts_m = 0; stop_m = 0;
        end
      end
    end
  end

  task automatic run_job(input logic [255:0] t, input logic [63:0] s, input logic [31:0] n,
                         input int n_issue, input status_t e);
    logic [255:0] tv;
    tv = t;
    if (n != 0) for (int k = 0; k < 8; k++) tgt_q.push_back(tv[32*k +: 32]);
    for (int k = 0; k < n_issue; k++) nonce_q.push_back(s + 64'(k));
    stat_q.push_back(e);
    @(posedge clk); #1;
    job_valid = 1'b1; job_target = t; job_nonce_start = s; job_nonce_count = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (job_ready) break;
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
    begin : wait_done
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        @(negedge clk);
        if (done) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        $display("FAIL done_wait: got no done pulse within budget, required one");
        checks++;
        stat_q.delete();
      end
    end
    @(negedge clk);
    check("target_q_drained", 64'(tgt_q.size()), 64'd0);
    check("nonce_q_drained", 64'(nonce_q.size()), 64'd0);
    tgt_q.delete();
    nonce_q.delete();
  endtask

  function automatic status_t mk(logic f, logic a, logic t, logic [63:0] g, int st, int sl);
    status_t r;
    r.found = f; r.aborted = a; r.timeout = t; r.golden = g; r.starts = st; r.stop_len = sl;
    return r;
  endfunction

  localparam logic [255:0] T_HI  = {32'h0000_00FF, {7{32'hFFFF_FFFF}}};
  localparam logic [255:0] T_SEQ = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555,
                                    32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [255:0] T_MIX = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1234_5678,
                                    32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hA5A5_5A5A, 32'h0000_0001};

  initial begin
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; target_full = 1'b0;
    job_target = '0; job_nonce_start = '0; job_nonce_count = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {55'd0, job_ready, busy, done, target_we, cmp_start, cmp_stop,
                         nonce_valid, found, aborted, timeout},
          {55'd0, 1'b1, 9'd0});
    check("reset_golden", golden_nonce, 64'd0);
    check("reset_target_data", {32'd0, target_data}, 64'd0);

    // Hit after 3 retires: golden = 0x10 + 3.
    hit_after = 3;
    run_job(T_HI, 64'h10, 32'd4, 4, mk(1'b1, 1'b0, 1'b0, 64'h13, 1, 2));
    hit_after = -1;

    // Zero-length job: straight to REPORT, clears previous status.
    run_job(T_SEQ, 64'h77, 32'd0, 0, mk(1'b0, 1'b0, 1'b0, 64'd0, 0, 0));

    // Four nonces, no hit: ends when all four retire.
    run_job(T_SEQ, 64'h100, 32'd4, 4, mk(1'b0, 1'b0, 1'b0, 64'd0, 1, 2));

    // Target FIFO full for 5 cycles during the load.
    fork
      run_job(T_MIX, 64'h55, 32'd1, 1, mk(1'b0, 1'b0, 1'b0, 64'd0, 1, 2));
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (busy) break;
        end
        repeat (2) @(posedge clk);
        #1 target_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 target_full = 1'b0;
      end
    join

    // Abort after two nonces issued; ack glitches once before a clean drain.
    ready_mode = 2; ready_limit = 2; ack_mode = 1;
    fork
      run_job(T_SEQ, 64'h200, 32'd4, 2, mk(1'b0, 1'b1, 1'b0, 64'd0, 1, 7));
      begin
        for (int k = 0; k < 200; k++) begin
          @(posedge clk); #1;
          if (iss >= 2) break;
        end
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (cmp_stop) break;
        end
        @(posedge clk); #1 abort = 1'b0;
      end
    join
    ready_mode = 0; ack_mode = 0;

    // Nonce wrap with toggling ready: FE, FF, 0.
    ready_mode = 1;
    run_job(T_MIX, 64'hFFFF_FFFF_FFFF_FFFE, 32'd3, 3, mk(1'b0, 1'b0, 1'b0, 64'd0, 1, 2));
    ready_mode = 0;

`ifdef HASH_JOB_STOP_WDOG_EN
    // Drain never acknowledged: watchdog ends STOP_WAIT after 16 cycles.
    ack_mode = 2;
    run_job(T_SEQ, 64'h300, 32'd2, 2, mk(1'b0, 1'b0, 1'b1, 64'd0, 1, 16));
    ack_mode = 0;
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got simulation still running, required finish");
    $fatal(1);
  end

endmodule
